// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_arb_pkg
//  Description : Shared definitions for the i2c_master request arbiter:
//                FSM state encoding, payload widths and the timeout counter
//                width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_FINISH    = 3'd4
    } arb_state_t;

    // Width able to hold the larger of the two timeout limits.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_req_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Returns the first set
//                request bit at or after ptr, wrapping NUM_REQ-1 -> 0.
//  Ports       : req     - request vector
//                ptr     - round-robin start position
//                win_oh  - one-hot winner (zero when no request)
//                win_idx - winner index (zero when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_pos;

    // Scan from the farthest offset down to offset 0 so the nearest set bit
    // to ptr is the last one written and therefore wins.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
            end
            w_pos = w_sum[IDX_W-1:0];
            if (req[w_pos]) begin
                win_oh        = '0;
                win_oh[w_pos] = 1'b1;
                win_idx       = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_req_arbiter
//  Description : Round-robin scheduler sharing one i2c_master write engine
//                among NUM_REQ requesters. Latches the winner's address and
//                data, pulses m_start, tracks m_busy with start/transaction
//                timeouts and returns a one-cycle done or err pulse.
//  Ports       : clk, rst_n (sync, active-low)
//                req / req_addr / req_data  - client requests and payloads
//                gnt / done / err           - one-hot client responses
//                m_start / m_slave_addr / m_data_byte / m_busy - master side
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16,
    parameter int TXN_TIMEOUT   = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        err,
    output logic                      m_start,
    output logic [ADDR_W-1:0]         m_slave_addr,
    output logic [DATA_W-1:0]         m_data_byte,
    input  logic                      m_busy
);

    localparam int c_idx_w = $clog2(NUM_REQ);
    localparam int c_cnt_w = cnt_width(START_TIMEOUT, TXN_TIMEOUT);

    // A wait state lasts exactly LIMIT cycles: the counter starts at 0 on
    // entry and the abort is taken on the edge where it holds LIMIT-1.
    localparam logic [c_cnt_w-1:0] c_start_lim = c_cnt_w'(START_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_txn_lim   = c_cnt_w'(TXN_TIMEOUT - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic                 w_fail;
    logic                 r_fail;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_idx_w-1:0]   r_ptr;
    logic [NUM_REQ-1:0]   r_win_oh;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [c_idx_w-1:0]   w_pick_idx;
    logic                 w_launch;
    logic                 w_in_txn;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_pick (
        .req     (req),
        .ptr     (r_ptr),
        .win_oh  (w_pick_oh),
        .win_idx (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fail      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Busy while idle means the master is doing someone else's
                // work (or is stuck); never launch on top of it.
                if ((|req) && !m_busy) begin
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (m_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_cnt >= c_start_lim) begin
                    w_state_nxt = ST_FINISH;
                    w_fail      = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!m_busy) begin
                    w_state_nxt = ST_FINISH;
                end else if (r_cnt >= c_txn_lim) begin
                    w_state_nxt = ST_FINISH;
                    w_fail      = 1'b1;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_launch = (r_state == ST_IDLE) && (w_state_nxt == ST_LAUNCH);

    // Counter runs only while remaining in the same state; any transition
    // restarts it, which covers both the LAUNCH and WAIT_BUSY exits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (r_cnt != {c_cnt_w{1'b1}}) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_win_oh     <= '0;
            r_fail       <= 1'b0;
            m_slave_addr <= '0;
            m_data_byte  <= '0;
        end else begin
            if (w_launch) begin
                r_win_oh     <= w_pick_oh;
                m_slave_addr <= req_addr[w_pick_idx*ADDR_W +: ADDR_W];
                m_data_byte  <= req_data[w_pick_idx*DATA_W +: DATA_W];
                r_ptr        <= (w_pick_idx == c_idx_w'(NUM_REQ - 1)) ?
                                '0 : w_pick_idx + 1'b1;
            end
            if (w_state_nxt == ST_FINISH && r_state != ST_FINISH) begin
                r_fail <= w_fail;
            end
        end
    end

    // All client/master strobes decode from the registered state, so they
    // are glitch-free and clear together on reset.
    assign w_in_txn = (r_state == ST_LAUNCH) || (r_state == ST_WAIT_BUSY) ||
                      (r_state == ST_WAIT_DONE);
    assign m_start  = (r_state == ST_LAUNCH);
    assign gnt      = w_in_txn ? r_win_oh : '0;
    assign done     = ((r_state == ST_FINISH) && !r_fail) ? r_win_oh : '0;
    assign err      = ((r_state == ST_FINISH) &&  r_fail) ? r_win_oh : '0;

endmodule
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_req_arbiter
//  Description : Directed self-checking bench for i2c_req_arbiter with a
//                hand-driven model of the master's busy flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_req_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [27:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  err;
    logic        m_start;
    logic [6:0]  m_slave_addr;
    logic [7:0]  m_data_byte;
    logic        m_busy;

    int checks;
    int errors;

    logic [6:0] exp_a [4];
    logic [7:0] exp_d [4];

    i2c_req_arbiter #(
        .NUM_REQ       (4),
        .START_TIMEOUT (16),
        .TXN_TIMEOUT   (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .m_start      (m_start),
        .m_slave_addr (m_slave_addr),
        .m_data_byte  (m_data_byte),
        .m_busy       (m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the LAUNCH cycle and checks grant and payload.
    task automatic wait_start(input logic [3:0] oh, input logic [6:0] a, input logic [7:0] d);
        int n;
        n = 0;
        while (!m_start && n < 20) begin
            tick();
            n++;
        end
        chk("start_seen", m_start, 1);
        chk("gnt_at_start", gnt, oh);
        chk("addr_at_start", m_slave_addr, a);
        chk("data_at_start", m_data_byte, d);
    endtask

    // One complete successful transaction; busy rises 2 cycles after m_start
    // and stays high for blen cycles. Payload inputs are inverted during the
    // transaction to show the latched values are isolated from them.
    task automatic run_txn(input int idx, input int blen, input logic [3:0] req_after);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        wait_start(oh, exp_a[idx], exp_d[idx]);
        req_addr = ~req_addr;
        req_data = ~req_data;
        tick();
        chk("m_start_one_cycle", m_start, 0);
        chk("gnt_held", gnt, oh);
        tick();
        m_busy = 1'b1;
        repeat (blen) tick();
        m_busy = 1'b0;
        tick();
        chk("done_pulse", done, oh);
        chk("err_quiet", err, 0);
        chk("gnt_drop", gnt, 0);
        chk("addr_isolated", m_slave_addr, exp_a[idx]);
        chk("data_isolated", m_data_byte, exp_d[idx]);
        req_addr = ~req_addr;
        req_data = ~req_data;
        req = req_after;
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_gap", m_start, 0);
    endtask

    initial begin
        int seq2 [4];
        int seq3 [8];
        seq2 = '{1, 3, 1, 3};
        seq3 = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_a = '{7'h2A, 7'h11, 7'h12, 7'h13};
        exp_d = '{8'hB3, 8'hA1, 8'hA2, 8'hA3};
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = '0;
        m_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr[7*i +: 7] = exp_a[i];
            req_data[8*i +: 8] = exp_d[i];
        end

        // Reset state
        tick();
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_m_start", m_start, 0);
        chk("rst_addr", m_slave_addr, 0);
        chk("rst_data", m_data_byte, 0);
        rst_n = 1'b1;
        tick();

        // Single request from requester 0
        req = 4'b0001;
        run_txn(0, 20, 4'b0000);

        // Two simultaneous requesters alternate (pointer starts at 1)
        req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            run_txn(seq2[i], 4, (i == 3) ? 4'b0000 : 4'b1010);
        end

        // All four requesting: strict rotation
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            run_txn(seq3[i], 4, (i == 7) ? 4'b0000 : 4'b1111);
        end

        // Start timeout: busy never rises
        req = 4'b0100;
        wait_start(4'b0100, exp_a[2], exp_d[2]);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("st_to_err_early", err, 0);
        end
        tick();
        chk("st_to_err", err, 4'b0100);
        chk("st_to_done", done, 0);
        chk("st_to_gnt", gnt, 0);
        req = 4'b0000;
        tick();
        chk("st_to_err_one_cycle", err, 0);
        req = 4'b0010;
        run_txn(1, 4, 4'b0000);

        // Transaction timeout: busy stuck high (pointer now 2 -> winner 0)
        req = 4'b0001;
        wait_start(4'b0001, exp_a[0], exp_d[0]);
        tick();
        tick();
        m_busy = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("txn_to_err_early", err, 0);
        end
        tick();
        chk("txn_to_err", err, 4'b0001);
        chk("txn_to_done", done, 0);
        chk("txn_to_gnt", gnt, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_blocks_gnt", gnt, 0);
            chk("busy_blocks_start", m_start, 0);
        end

        // Release busy, launch again, then reset in WAIT_DONE
        m_busy = 1'b0;
        wait_start(4'b0001, exp_a[0], exp_d[0]);
        tick();
        tick();
        m_busy = 1'b1;
        tick();
        tick();
        chk("pre_rst_gnt", gnt, 4'b0001);
        rst_n  = 1'b0;
        m_busy = 1'b0;
        req    = 4'b0000;
        tick();
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_m_start", m_start, 0);
        chk("mid_rst_addr", m_slave_addr, 0);
        chk("mid_rst_data", m_data_byte, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", done, 0);
        chk("post_rst_err", err, 0);
        // Pointer back at 0: requester 0 beats 3 first, then 3 is served
        req = 4'b1001;
        run_txn(0, 4, 4'b1001);
        run_txn(3, 4, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
